// File: rtl/clock_pkg.sv
// Shared types and defaults for the digital-clock sequencing logic.
package clock_pkg;

    typedef enum logic [1:0] {
        ModeRun    = 2'd0,
        ModeSetHr  = 2'd1,
        ModeSetMin = 2'd2
    } mode_e;

    localparam int unsigned DefSecMod = 60;
    localparam int unsigned DefMinMod = 60;
    localparam int unsigned DefHrMod  = 24;

    // Width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clock_timeout_cnt.sv
// Set-mode inactivity timer: counts remaining ticks down and flags the expiring tick.
module clock_timeout_cnt
    import clock_pkg::*;
#(
    parameter int unsigned TIMEOUT_S = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic tick,
    output logic expired
);

    localparam int unsigned W = cnt_width(TIMEOUT_S);
    // "Zero ticks elapsed" is represented as TIMEOUT_S-1 ticks remaining.
    localparam logic [W-1:0] Load = W'(TIMEOUT_S - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Reload on clear, otherwise count down one step per tick.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = Load;
        end else if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Remaining-tick register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= Load;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A clear in the same cycle (button activity) overrides expiry.
    assign expired = tick & ~clr & (cnt_q == '0);

endmodule

// File: rtl/clock_seq_ctrl.sv
// Clock sequencing FSM: cascades the 1 Hz tick in RUN, routes increments in set modes.
module clock_seq_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned SEC_MOD   = DefSecMod,
    parameter int unsigned MIN_MOD   = DefMinMod,
    parameter int unsigned HR_MOD    = DefHrMod,
    parameter int unsigned TIMEOUT_S = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick_1hz,
    input  logic                       btn_mode,
    input  logic                       btn_inc,
    input  logic [$clog2(SEC_MOD)-1:0] sec,
    input  logic [$clog2(MIN_MOD)-1:0] min,
    input  logic [$clog2(HR_MOD)-1:0]  hr,
    output logic                       sec_en,
    output logic                       min_en,
    output logic                       hr_en,
    output logic                       sec_clr,
    output logic [1:0]                 mode,
    output logic                       blink
);

    localparam int unsigned SecW = $clog2(SEC_MOD);
    localparam int unsigned MinW = $clog2(MIN_MOD);
    localparam logic [SecW-1:0] SecLast = SecW'(SEC_MOD - 1);
    localparam logic [MinW-1:0] MinLast = MinW'(MIN_MOD - 1);

    mode_e mode_q, mode_d;
    logic  blink_q, blink_d;
    logic  in_set, to_clr, to_expired;
    logic  sec_wrap, min_wrap;

    // Hours value is not needed: the hours counter wraps on its own.
    logic unused_hr;
    assign unused_hr = ^hr;

    assign in_set   = (mode_q == ModeSetHr) || (mode_q == ModeSetMin);
    // Timer restarts on any button, and is held cleared outside set modes.
    assign to_clr   = ~in_set | btn_inc | btn_mode;
    assign sec_wrap = (sec == SecLast);
    assign min_wrap = (min == MinLast);

    clock_timeout_cnt #(
        .TIMEOUT_S (TIMEOUT_S)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (to_clr),
        .tick    (tick_1hz),
        .expired (to_expired)
    );

    // Next-state, blink and zero-latency counter controls.
    always_comb begin
        mode_d  = mode_q;
        blink_d = blink_q;
        sec_en  = 1'b0;
        min_en  = 1'b0;
        hr_en   = 1'b0;
        sec_clr = 1'b0;
        unique case (mode_q)
            ModeRun: begin
                blink_d = 1'b0;
                sec_en  = tick_1hz;
                min_en  = tick_1hz & sec_wrap;
                hr_en   = tick_1hz & sec_wrap & min_wrap;
                if (btn_mode) begin
                    mode_d  = ModeSetHr;
                    blink_d = 1'b1;
                end
            end
            ModeSetHr: begin
                if (btn_mode) begin
                    mode_d  = ModeSetMin;
                    blink_d = 1'b1;
                end else begin
                    hr_en = btn_inc;
                    if (to_expired) begin
                        mode_d  = ModeRun;
                        blink_d = 1'b0;
                    end else if (tick_1hz) begin
                        blink_d = ~blink_q;
                    end
                end
            end
            ModeSetMin: begin
                if (btn_mode) begin
                    mode_d  = ModeRun;
                    blink_d = 1'b0;
                    sec_clr = 1'b1;
                end else begin
                    min_en = btn_inc;
                    if (to_expired) begin
                        mode_d  = ModeRun;
                        blink_d = 1'b0;
                        sec_clr = 1'b1;
                    end else if (tick_1hz) begin
                        blink_d = ~blink_q;
                    end
                end
            end
            default: begin
                mode_d  = ModeRun;
                blink_d = 1'b0;
            end
        endcase
        // Counters must stay still while reset is held.
        if (rst) begin
            sec_en  = 1'b0;
            min_en  = 1'b0;
            hr_en   = 1'b0;
            sec_clr = 1'b0;
        end
    end

    // Mode and blink registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= ModeRun;
            blink_q <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            blink_q <= blink_d;
        end
    end

    assign mode  = mode_q;
    assign blink = blink_q;

endmodule

// File: tb/tb_clock_seq_ctrl.sv
// Scoreboard bench for clock_seq_ctrl: directed sequences plus randomized traffic.
module tb_clock_seq_ctrl;

    localparam int TimeoutS = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [5:0] sec = '0;
    logic [5:0] min = '0;
    logic [4:0] hr = '0;
    logic       sec_en, min_en, hr_en, sec_clr, blink;
    logic [1:0] mode;

    clock_seq_ctrl #(
        .SEC_MOD   (60),
        .MIN_MOD   (60),
        .HR_MOD    (24),
        .TIMEOUT_S (TimeoutS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_1hz (tick_1hz),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .sec      (sec),
        .min      (min),
        .hr       (hr),
        .sec_en   (sec_en),
        .min_en   (min_en),
        .hr_en    (hr_en),
        .sec_clr  (sec_clr),
        .mode     (mode),
        .blink    (blink)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit sv;
        bit se;
        bit me;
        bit he;
        bit sc;
        int md;
        bit bl;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    // Reference model: mode 0 run, 1 set hours, 2 set minutes.
    int m_mode = 0;
    int m_idle = 0;   // ticks seen in a set mode since last activity
    bit m_blink = 1'b0;
    bit m_valid = 1'b0;

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    endtask

    task automatic step(input bit r, input bit t, input bit bm, input bit bi,
                        input int s, input int mi, input int h);
        exp_t e;
        @(negedge clk);
        rst = r;
        tick_1hz = t;
        btn_mode = bm;
        btn_inc = bi;
        sec = 6'(s);
        min = 6'(mi);
        hr = 5'(h);
        e.sv = m_valid;
        e.md = m_mode;
        e.bl = m_blink;
        e.se = 0;
        e.me = 0;
        e.he = 0;
        e.sc = 0;
        if (r) begin
            m_mode = 0;
            m_blink = 0;
            m_idle = 0;
            m_valid = 1;
        end else if (m_mode == 0) begin
            e.se = t;
            e.me = t && (s == 59);
            e.he = e.me && (mi == 59);
            if (bm) begin
                m_mode = 1;
                m_blink = 1;
                m_idle = 0;
            end
        end else if (bm) begin
            if (m_mode == 2) begin
                e.sc = 1;
                m_mode = 0;
                m_blink = 0;
            end else begin
                m_mode = 2;
                m_blink = 1;
            end
            m_idle = 0;
        end else if (bi) begin
            if (m_mode == 1) e.he = 1;
            else e.me = 1;
            m_idle = 0;
            if (t) m_blink = !m_blink;
        end else if (t) begin
            if (m_idle + 1 == TimeoutS) begin
                if (m_mode == 2) e.sc = 1;
                m_mode = 0;
                m_blink = 0;
                m_idle = 0;
            end else begin
                m_idle++;
                m_blink = !m_blink;
            end
        end
        q.push_back(e);
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 30, 30, 12);
    endtask

    // Monitor: every cycle the DUT presents a full set of outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("sec_en", int'(sec_en), int'(e.se));
                chk("min_en", int'(min_en), int'(e.me));
                chk("hr_en", int'(hr_en), int'(e.he));
                chk("sec_clr", int'(sec_clr), int'(e.sc));
                if (e.sv) begin
                    chk("mode", int'(mode), e.md);
                    chk("blink", int'(blink), int'(e.bl));
                end
            end
        end
    end

    initial begin
        int  r_sec, r_min, r_hr, pb;
        bit  r_t, r_bm, r_bi, r_rst;
        // Reset then three plain ticks.
        step(1, 1, 1, 1, 59, 59, 23);
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, i, 0, 0);
        // Carry cascade.
        step(0, 1, 0, 0, 59, 59, 23);
        step(0, 1, 0, 0, 59, 10, 5);
        // Set flow: hours, minutes, back to run.
        step(0, 0, 1, 0, 5, 5, 5);
        step(0, 0, 0, 1, 5, 5, 5);
        step(0, 1, 0, 0, 5, 5, 5);
        step(0, 0, 0, 1, 5, 5, 5);
        step(0, 1, 0, 0, 5, 5, 5);
        step(0, 0, 1, 0, 5, 5, 5);
        step(0, 0, 0, 1, 5, 5, 5);
        step(0, 0, 1, 0, 5, 5, 5);
        step(0, 0, 0, 0, 5, 5, 5);
        // Timeout in SET_MIN, restarted by an increment after tick 9.
        step(0, 0, 1, 0, 5, 5, 5);
        step(0, 0, 1, 0, 5, 5, 5);
        idle_ticks(9);
        step(0, 0, 0, 1, 5, 5, 5);
        idle_ticks(10);
        step(0, 0, 0, 0, 5, 5, 5);
        // Collisions.
        step(0, 0, 1, 0, 5, 5, 5);
        step(0, 0, 1, 1, 5, 5, 5);
        step(0, 0, 1, 0, 5, 5, 5);
        step(0, 1, 1, 0, 59, 20, 5);
        // Reset while in SET_MIN.
        step(0, 0, 1, 0, 5, 5, 5);
        step(1, 1, 0, 1, 59, 59, 23);
        step(0, 0, 0, 0, 5, 5, 5);
        // Randomized traffic, alternating busy and sparse-button phases.
        for (int i = 0; i < 3000; i++) begin
            pb = (((i / 400) % 2) == 1) ? 2 : 12;
            r_t = ($urandom_range(0, 99) < 50);
            r_bm = ($urandom_range(0, 99) < pb);
            r_bi = ($urandom_range(0, 99) < pb);
            r_rst = ($urandom_range(0, 999) < 3);
            r_sec = ($urandom_range(0, 3) == 0) ? 59 : $urandom_range(0, 59);
            r_min = ($urandom_range(0, 2) == 0) ? 59 : $urandom_range(0, 59);
            r_hr = $urandom_range(0, 23);
            step(r_rst, r_t, r_bm, r_bi, r_sec, r_min, r_hr);
        end
        @(negedge clk);
        rst = 0;
        tick_1hz = 0;
        btn_mode = 0;
        btn_inc = 0;
        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
